// File: rtl/ex_type_i_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_type_i_if : issue/writeback handshake bundle for ex_type_i          |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface ex_type_i_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int RADDR_WIDTH = 5
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [DATA_WIDTH-1:0]  inst_i;
    logic [RDATA_WIDTH-1:0] op1_i;
    logic [RDATA_WIDTH-1:0] op2_i;
    logic                   reg_we_i;
    logic [RADDR_WIDTH-1:0] reg_waddr_i;
    logic                   flush_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [RDATA_WIDTH-1:0] reg_wdata_o;
    logic                   reg_we_o;
    logic [RADDR_WIDTH-1:0] reg_waddr_o;
    logic                   busy_o;

    modport master (
        output in_valid_i, inst_i, op1_i, op2_i, reg_we_i, reg_waddr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, reg_wdata_o, reg_we_o, reg_waddr_o, busy_o
    );

    modport slave (
        input  in_valid_i, inst_i, op1_i, op2_i, reg_we_i, reg_waddr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, reg_wdata_o, reg_we_o, reg_waddr_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_type_i.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_type_i : RV32 I-type ALU with a bit-serial shifter (1 bit/cycle)    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module ex_type_i #(
    parameter int DATA_WIDTH  = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int RADDR_WIDTH = 5
) (
    input wire         clk,
    input wire         rst_n,
    ex_type_i_if.slave bus
);
    localparam logic [6:0] C_OPCODE_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [4:0]             r_count;
    logic [RDATA_WIDTH-1:0] r_work;
    logic                   r_shift_left;
    logic                   r_shift_arith;
    logic                   r_pend_we;
    logic [RADDR_WIDTH-1:0] r_pend_waddr;
    logic                   r_out_valid;
    logic                   r_we;
    logic [RDATA_WIDTH-1:0] r_wdata;
    logic [RADDR_WIDTH-1:0] r_waddr;
    logic                   r_busy;

    logic [6:0]             w_opcode;
    logic [2:0]             w_funct3;
    logic [4:0]             w_shamt;
    logic                   w_is_op_imm;
    logic                   w_is_shift;
    logic                   w_start_shift;
    logic                   w_new_we;
    logic                   w_accept;
    logic [RDATA_WIDTH-1:0] w_result;
    logic [RDATA_WIDTH-1:0] w_work_next;
    logic                   w_unused_inst;

    assign w_opcode      = bus.inst_i[6:0];
    assign w_funct3      = bus.inst_i[14:12];
    assign w_shamt       = bus.inst_i[24:20];
    assign w_is_op_imm   = (w_opcode == C_OPCODE_OP_IMM);
    assign w_is_shift    = w_is_op_imm && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));
    assign w_start_shift = w_is_shift && (w_shamt != 5'd0);
    assign w_new_we      = w_is_op_imm && bus.reg_we_i && (bus.reg_waddr_i != '0);
    assign w_unused_inst = ^{bus.inst_i[DATA_WIDTH-1:31], bus.inst_i[29:25],
                             bus.inst_i[19:15], bus.inst_i[11:7]};

    assign bus.in_ready_o  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready_i);
    assign w_accept        = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
    assign bus.out_valid_o = r_out_valid;
    assign bus.reg_wdata_o = r_wdata;
    assign bus.reg_we_o    = r_we;
    assign bus.reg_waddr_o = r_waddr;
    assign bus.busy_o      = r_busy;

    // Single-cycle result; a zero-amount shift falls through as op1 unchanged.
    always_comb begin
        w_result = '0;
        if (w_is_op_imm) begin
            case (w_funct3)
                3'b000:  w_result = bus.op1_i + bus.op2_i;
                3'b010:  w_result = {{(RDATA_WIDTH-1){1'b0}}, ($signed(bus.op1_i) < $signed(bus.op2_i))};
                3'b011:  w_result = {{(RDATA_WIDTH-1){1'b0}}, (bus.op1_i < bus.op2_i)};
                3'b100:  w_result = bus.op1_i ^ bus.op2_i;
                3'b110:  w_result = bus.op1_i | bus.op2_i;
                3'b111:  w_result = bus.op1_i & bus.op2_i;
                default: w_result = bus.op1_i;
            endcase
        end
    end

    always_comb begin
        w_work_next = '0;
        if (r_shift_left) begin
            w_work_next = {r_work[RDATA_WIDTH-2:0], 1'b0};
        end else if (r_shift_arith) begin
            w_work_next = {r_work[RDATA_WIDTH-1], r_work[RDATA_WIDTH-1:1]};
        end else begin
            w_work_next = {1'b0, r_work[RDATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_count       <= 5'd0;
            r_work        <= '0;
            r_shift_left  <= 1'b0;
            r_shift_arith <= 1'b0;
            r_pend_we     <= 1'b0;
            r_pend_waddr  <= '0;
            r_out_valid   <= 1'b0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_waddr       <= '0;
            r_busy        <= 1'b0;
        end else if (bus.flush_i) begin
            r_state     <= S_IDLE;
            r_count     <= 5'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_pend_we    <= w_new_we;
            r_pend_waddr <= bus.reg_waddr_i;
            if (w_start_shift) begin
                r_state       <= S_SHIFT;
                r_busy        <= 1'b1;
                r_out_valid   <= 1'b0;
                r_count       <= w_shamt;
                r_work        <= bus.op1_i;
                r_shift_left  <= (w_funct3 == 3'b001);
                r_shift_arith <= bus.inst_i[30];
            end else begin
                r_state     <= S_DONE;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b1;
                r_wdata     <= w_result;
                r_we        <= w_new_we;
                r_waddr     <= bus.reg_waddr_i;
            end
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_work  <= w_work_next;
                    r_count <= r_count - 5'd1;
                    // Last bit shifted this edge: publish straight from the shift path.
                    if (r_count == 5'd1) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_wdata     <= w_work_next;
                        r_we        <= r_pend_we;
                        r_waddr     <= r_pend_waddr;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_type_i.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ex_type_i : directed + random bench for ex_type_i                   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_ex_type_i;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ex_type_i_if #(.DATA_WIDTH(32), .RDATA_WIDTH(32), .RADDR_WIDTH(5)) bus ();

    ex_type_i #(.DATA_WIDTH(32), .RDATA_WIDTH(32), .RADDR_WIDTH(5)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] mk_sh(input logic [2:0] f3, input logic b30, input logic [4:0] sh, input logic [4:0] rd);
        return {1'b0, b30, 5'd0, sh, 5'd1, f3, rd, 7'b0010011};
    endfunction

    // Reference: whole-word arithmetic; shift latency is amount+1 cycles.
    function automatic void model(input logic [31:0] inst, op1, op2, input logic we, input logic [4:0] wa,
                                  output logic [31:0] res, output logic exp_we, output int lat);
        logic [4:0] sh;
        logic [2:0] f3;
        sh  = inst[24:20];
        f3  = inst[14:12];
        res = 32'd0;
        lat = 1;
        exp_we = 1'b0;
        if (inst[6:0] == 7'b0010011) begin
            exp_we = we && (wa != 5'd0);
            case (f3)
                3'b000: res = op1 + op2;
                3'b010: res = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
                3'b011: res = (op1 < op2) ? 32'd1 : 32'd0;
                3'b100: res = op1 ^ op2;
                3'b110: res = op1 | op2;
                3'b111: res = op1 & op2;
                3'b001: begin res = op1 << sh; lat = int'(sh) + 1; end
                default: begin
                    res = inst[30] ? 32'($signed(op1) >>> sh) : (op1 >> sh);
                    lat = int'(sh) + 1;
                end
            endcase
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] inst, op1, op2,
                          input logic we, input logic [4:0] wa, input int stall);
        logic [31:0] er;
        logic        ew;
        int          el;
        int          lat;
        int          busy_n;
        model(inst, op1, op2, we, wa, er, ew, el);
        check({tag, " in_ready"}, 32'(bus.in_ready_o), 32'd1);
        bus.in_valid_i  = 1'b1;
        bus.inst_i      = inst;
        bus.op1_i       = op1;
        bus.op2_i       = op2;
        bus.reg_we_i    = we;
        bus.reg_waddr_i = wa;
        bus.out_ready_i = (stall == 0);
        step();
        bus.in_valid_i = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!bus.out_valid_o && lat < 64) begin
            if (bus.busy_o) busy_n++;
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(el - 1));
        check({tag, " wdata"}, bus.reg_wdata_o, er);
        check({tag, " we"}, 32'(bus.reg_we_o), 32'(ew));
        if (inst[6:0] == 7'b0010011) check({tag, " waddr"}, 32'(bus.reg_waddr_o), 32'(wa));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) step();
            check({tag, " hold_valid"}, 32'(bus.out_valid_o), 32'd1);
            check({tag, " hold_wdata"}, bus.reg_wdata_o, er);
            bus.out_ready_i = 1'b1;
        end
        step();
        check({tag, " idle_after"}, 32'(bus.out_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [4:0]  sh;
        int          seen;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.inst_i      = '0;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.reg_we_i    = 1'b0;
        bus.reg_waddr_i = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;

        #2;
        check("rst out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst we", 32'(bus.reg_we_o), 32'd0);
        check("rst wdata", bus.reg_wdata_o, 32'd0);
        check("rst waddr", 32'(bus.reg_waddr_o), 32'd0);
        check("rst busy", 32'(bus.busy_o), 32'd0);
        check("rst in_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        step();
        rst_n = 1'b1;

        run_op("addi", mk_i(12'hFFD, 3'b000, 5'd3), 32'd5, 32'hFFFF_FFFD, 1'b1, 5'd3, 0);
        run_op("sltiu", mk_i(12'hFFF, 3'b011, 5'd4), 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd4, 0);
        run_op("slti", mk_i(12'hFFF, 3'b010, 5'd4), 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd4, 0);
        run_op("srai", mk_sh(3'b101, 1'b1, 5'd4, 5'd7), 32'h8000_0000, 32'd0, 1'b1, 5'd7, 0);
        run_op("srli", mk_sh(3'b101, 1'b0, 5'd4, 5'd7), 32'h8000_0000, 32'd0, 1'b1, 5'd7, 0);
        run_op("slli0", mk_sh(3'b001, 1'b0, 5'd0, 5'd8), 32'h1234_5678, 32'd0, 1'b1, 5'd8, 0);
        run_op("addi_rd0", mk_i(12'h001, 3'b000, 5'd0), 32'd9, 32'd1, 1'b1, 5'd0, 0);
        run_op("bubble", 32'h0020_81B3, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3, 0);

        // ORI held under backpressure, then handshake and new accept on one edge.
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.inst_i      = mk_i(12'h0F0, 3'b110, 5'd5);
        bus.op1_i       = 32'h0000_000F;
        bus.op2_i       = 32'h0000_00F0;
        bus.reg_we_i    = 1'b1;
        bus.reg_waddr_i = 5'd5;
        step();
        bus.in_valid_i = 1'b0;
        held = bus.reg_wdata_o;
        check("ori wdata", held, 32'h0000_00FF);
        for (int i = 0; i < 3; i++) step();
        check("ori hold_valid", 32'(bus.out_valid_o), 32'd1);
        check("ori hold_wdata", bus.reg_wdata_o, 32'h0000_00FF);
        check("ori hold_waddr", 32'(bus.reg_waddr_o), 32'd5);
        check("ori in_ready_low", 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.inst_i      = mk_i(12'h010, 3'b100, 5'd6);
        bus.op1_i       = 32'h0000_0011;
        bus.op2_i       = 32'h0000_0010;
        bus.reg_waddr_i = 5'd6;
        #1;
        check("ori in_ready_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        bus.in_valid_i = 1'b0;
        check("b2b valid", 32'(bus.out_valid_o), 32'd1);
        check("b2b wdata", bus.reg_wdata_o, 32'h0000_0001);
        check("b2b waddr", 32'(bus.reg_waddr_o), 32'd6);
        step();
        check("b2b idle", 32'(bus.out_valid_o), 32'd0);

        // Long shift flushed part-way.
        bus.in_valid_i = 1'b1;
        bus.inst_i     = mk_sh(3'b001, 1'b0, 5'd31, 5'd9);
        bus.op1_i      = 32'd1;
        step();
        bus.in_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.out_valid_o) seen++;
            step();
        end
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check("flush in_ready", 32'(bus.in_ready_o), 32'd1);
        check("flush busy", 32'(bus.busy_o), 32'd0);
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid_o) seen++;
            step();
        end
        check("flush no_valid", 32'(seen), 32'd0);

        // Flush beats a concurrent accept.
        bus.in_valid_i = 1'b1;
        bus.inst_i     = mk_i(12'h001, 3'b000, 5'd2);
        bus.flush_i    = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        check("flush_acc valid", 32'(bus.out_valid_o), 32'd0);
        check("flush_acc busy", 32'(bus.busy_o), 32'd0);

        // Asynchronous reset mid-shift drops the instruction.
        run_op("pre_rst", mk_i(12'h123, 3'b000, 5'd10), 32'h1000_0000, 32'h123, 1'b1, 5'd10, 0);
        bus.in_valid_i = 1'b1;
        bus.inst_i     = mk_sh(3'b001, 1'b0, 5'd20, 5'd11);
        bus.op1_i      = 32'h0000_0003;
        step();
        bus.in_valid_i = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", 32'(bus.out_valid_o), 32'd0);
        check("arst we", 32'(bus.reg_we_o), 32'd0);
        check("arst wdata", bus.reg_wdata_o, 32'd0);
        check("arst waddr", 32'(bus.reg_waddr_o), 32'd0);
        check("arst busy", 32'(bus.busy_o), 32'd0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid_o) seen++;
            step();
        end
        check("arst no_result", 32'(seen), 32'd0);

        // Randomized mix with occasional backpressure.
        for (int n = 0; n < 60; n++) begin
            f3  = 3'($urandom_range(0, 7));
            op1 = $urandom;
            imm = 12'($urandom);
            sh  = 5'($urandom_range(0, 31));
            if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                inst = mk_sh(f3, (f3 == 3'b101) ? 1'($urandom) : 1'b0, sh, 5'($urandom));
                op2  = 32'd0;
            end else begin
                inst = mk_i(imm, f3, 5'($urandom));
                op2  = {{20{imm[11]}}, imm};
            end
            if ($urandom_range(0, 7) == 0) inst[6:0] = 7'b0110011;
            run_op("rand", inst, op1, op2, 1'($urandom), inst[11:7], int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_type_i.md
EX_TYPE_I -- requirements
Module: ex_type_i

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction width.
REQ-002 Parameter RDATA_WIDTH, default 32: operand/result width.
REQ-003 Parameter RADDR_WIDTH, default 5: register address width.
REQ-004 Clock and reset SHALL be: one clock `clk`; reset `rst_n`, asynchronous, active-low.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid_i  in  1  decoded I-type instruction present.
REQ-008 in_ready_o  out  1  block accepts input this cycle.
REQ-009 inst_i  in  DATA_WIDTH  raw instruction (opcode, funct3, shamt, bit 30).
REQ-010 op1_i  in  RDATA_WIDTH  rs1 value.
REQ-011 op2_i  in  RDATA_WIDTH  sign-extended imm; zero for SLLI/SRLI/SRAI.
REQ-012 reg_we_i  in  1  decoder write enable.
REQ-013 reg_waddr_i  in  RADDR_WIDTH  destination rd.
REQ-014 flush_i  in  1  discard in-flight and pending instruction.
REQ-015 out_valid_o  out  1  result valid.
REQ-016 out_ready_i  in  1  downstream (writeback) accepts result.
REQ-017 reg_wdata_o  out  RDATA_WIDTH  result.
REQ-018 reg_we_o  out  1  writeback enable.
REQ-019 reg_waddr_o  out  RADDR_WIDTH  writeback address.
REQ-020 busy_o  out  1  high in SHIFT state.

Function
REQ-021 Accept = in_valid_i & in_ready_o & !flush_i at rising edge.
REQ-022 in_ready_o = (state==IDLE) | (state==DONE & out_ready_i); combinational; back-to-back accept allowed.
REQ-023 States: IDLE, SHIFT, DONE; IDLE->DONE on accept of non-shift; IDLE->SHIFT on accept of shift with shamt!=0; IDLE->DONE on shift with shamt==0; SHIFT->DONE when count reaches 0; DONE->IDLE on out handshake without new accept; DONE->DONE/SHIFT on handshake with same-cycle accept.
REQ-024 funct3 decode: 000 ADDI op1+op2 (mod 2^32); 010 SLTI signed op1<op2 ->1 else 0; 011 SLTIU unsigned compare; 100 XORI; 110 ORI; 111 ANDI.
REQ-025 001 SLLI, 101 SRLI (inst[30]=0) / SRAI (inst[30]=1): shamt = inst_i[24:20]; op2_i ignored.
REQ-026 Non-shift latency: out_valid_o high the cycle after accept.
REQ-027 Shift: serial, 1 bit per cycle; working reg loaded with op1_i, counter loaded with shamt; out_valid_o high shamt+1 cycles after accept (shamt 0 -> 1 cycle).
REQ-028 SRAI fills with original bit 31; SRLI/SLLI fill with 0.
REQ-029 inst_i[6:0] != 7'b0010011 accepted as bubble: latency 1, reg_wdata_o=0, reg_we_o=0.
REQ-030 reg_we_o = reg_we_i & (reg_waddr_i!=0), captured at accept.
REQ-031 In DONE with out_ready_i=0, reg_wdata_o/reg_we_o/reg_waddr_o/out_valid_o SHALL hold stable.
REQ-032 out_valid_o SHALL be 0 in IDLE and SHIFT.
REQ-033 flush_i at edge: state->IDLE, out_valid_o->0, any concurrent accept discarded; flush wins over all other events.
REQ-034 reg_wdata_o/reg_waddr_o outside DONE: hold last value (don't-care to consumer).

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, counter 0, out_valid_o 0, reg_we_o 0, reg_wdata_o 0, reg_waddr_o 0, busy_o 0, independent of clk.
REQ-036 Reset mid-SHIFT SHALL drop the instruction; no result emitted after release.
REQ-037 First accept possible on first rising edge after rst_n deasserts.

Verification
REQ-038 ADDI op1=5, op2=0xFFFFFFFD, rd=3 -> next cycle out_valid=1, wdata=2, we=1, waddr=3.
REQ-039 SLTIU op1=1, op2=0xFFFFFFFF -> wdata=1; SLTI same operands -> wdata=0.
REQ-040 SRAI op1=0x80000000 shamt=4 -> busy 4 cycles, out_valid 5 cycles after accept, wdata=0xF8000000; SRLI same -> 0x08000000.
REQ-041 ORI result held with out_ready=0 for 3 cycles -> outputs stable, in_ready=0; on ready=1 with in_valid=1 -> handshake and new accept same edge.
REQ-042 SLLI shamt=31 accepted, flush_i pulsed 10 cycles later -> out_valid never rises, in_ready=1 next cycle.
REQ-043 ADDI rd=0 -> we=0; rst_n low during shift -> all outputs 0 asynchronously, no later result.
